alu_issue_seq: RTL

//  Issue sequencer directly upstream of the 8-bit combinational alu: holds an NREG x DW register file,

---
 rtl/alu_issue_seq_pkg.sv | 24 ++
 rtl/alu.sv | 25 ++
 rtl/alu_seq_regfile.sv | 49 ++++
 rtl/alu_issue_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the alu issue sequencer and the alu: opcodes, FSM states, legality check.
package alu_issue_seq_pkg;

   localparam int OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_PLUS   = 3'd0,
      OP_MINUS  = 3'd1,
      OP_AND    = 3'd2,
      OP_OR     = 3'd3,
      OP_NEGATE = 3'd4
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } seq_state_e;

   // Opcodes above OP_NEGATE have no alu function and are reported as errors.
   function automatic logic op_is_legal(input logic [OPW-1:0] op);
      return op <= OP_NEGATE;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational DW-bit alu: modulo add/subtract, bitwise and/or, bitwise negate of a.
module alu
   import alu_issue_seq_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [OPW-1:0] opcode,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   output logic [DW-1:0]  out
);

   always_comb begin
      out = '0;
      case (opcode)
         OP_PLUS:   out = a + b;
         OP_MINUS:  out = a - b;
         OP_AND:    out = a & b;
         OP_OR:     out = a | b;
         OP_NEGATE: out = ~a;
         default:   out = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: three asynchronous read ports, one synchronous write port, sync active-low clear.
module alu_seq_regfile #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr0,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [DW-1:0] rdata2
);

   localparam int NREG = 2 ** AW;

   logic [DW-1:0] mem_q [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_entry
         logic [DW-1:0] mem_d;

         always_comb begin
            mem_d = mem_q[gi];
            if (we && (waddr == AW'(gi))) begin
               mem_d = wdata;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               mem_q[gi] <= '0;
            end else begin
               mem_q[gi] <= mem_d;
            end
         end
      end
   endgenerate

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];
   assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer feeding the combinational alu: reads operands, registers them, writes the result back.
// Optional zero_flag output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     in_op,
   input  logic [AW-1:0]  in_rd,
   input  logic [AW-1:0]  in_rs1,
   input  logic [AW-1:0]  in_rs2,
   input  logic           ld_valid,
   output logic           ld_ready,
   input  logic [AW-1:0]  ld_addr,
   input  logic [DW-1:0]  ld_data,
   output logic [2:0]     alu_opcode,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [DW-1:0]  alu_out,
   output logic           done,
   output logic [DW-1:0]  result,
   output logic           err,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic           zero_flag,
`endif
   input  logic [AW-1:0]  dbg_addr,
   output logic [DW-1:0]  dbg_data
);

   seq_state_e     state_q, state_d;
   logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
   logic [DW-1:0]  alu_a_q, alu_a_d;
   logic [DW-1:0]  alu_b_q, alu_b_d;
   logic [AW-1:0]  rd_q, rd_d;
   logic [DW-1:0]  result_q, result_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic           zero_flag_q, zero_flag_d;
`endif

   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic [DW-1:0]  wr_data;
   logic [DW-1:0]  rs1_data;
   logic [DW-1:0]  rs2_data;

   alu_seq_regfile #(
      .DW (DW),
      .AW (AW)
   ) u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wr_en),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .raddr0 (in_rs1),
      .raddr1 (in_rs2),
      .raddr2 (dbg_addr),
      .rdata0 (rs1_data),
      .rdata1 (rs2_data),
      .rdata2 (dbg_data)
   );

   assign in_ready = (state_q == ST_IDLE) && rst_n;
   // An instruction always takes priority over a load presented in the same cycle.
   assign ld_ready = (state_q == ST_IDLE) && !in_valid && rst_n;

   always_comb begin
      state_d      = state_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rd_d         = rd_q;
      result_d     = result_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_flag_d  = zero_flag_q;
`endif
      wr_en        = 1'b0;
      wr_addr      = ld_addr;
      wr_data      = ld_data;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (op_is_legal(in_op)) begin
                  alu_opcode_d = in_op;
                  alu_a_d      = rs1_data;
                  alu_b_d      = rs2_data;
                  rd_d         = in_rd;
                  state_d      = ST_EXEC;
               end else begin
                  err_d = 1'b1;
               end
            end else if (ld_valid) begin
               wr_en = 1'b1;
            end
         end
         ST_EXEC: begin
            // The alu is combinational on the registered operands, so its output is valid here.
            wr_en       = 1'b1;
            wr_addr     = rd_q;
            wr_data     = alu_out;
            result_d    = alu_out;
            done_d      = 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_flag_d = (alu_out == '0);
`endif
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rd_q         <= '0;
         result_q     <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zero_flag_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rd_q         <= rd_d;
         result_q     <= result_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zero_flag_q  <= zero_flag_d;
`endif
      end
   end

   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign done       = done_q;
   assign result     = result_q;
   assign err        = err_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign zero_flag  = zero_flag_q;
`endif

endmodule
